rv_bus_fabric: RTL and testbench
================================

# rv_bus_fabric

Parametrised bus fabric between the PicoRV32 native memory interface and up to NUM_SLAVES memory/peripheral regions. It replaces the fixed always-ready decode (internal RAM / external RAM / peripherals) with a table-driven one. Each region either has a fixed wait-state count or uses a slave ready handshake. The fabric adds a timeout, reports unmapped or timed-out accesses, and gives write strobes as single-cycle pulses so FIFO-style peripherals see exactly one write per store.

## Interface
Parameters:
- NUM_SLAVES, 4: number of regions, 1..8.
- SLV_BASE, {32'h8001_0000, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000}: packed NUM_SLAVES×32 base addresses; slave i is at bits [32i+31:32i].
- SLV_MASK, {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}: packed compare masks. Slave i matches when (m_addr & MASK_i) == BASE_i.
- SLV_WAIT, {4'd0, 4'd1, 4'd1, 4'd1}: packed NUM_SLAVES×4 values. 0 selects handshake mode; W=1..15 gives a fixed access of W cycles.
- TIMEOUT, 255: number of handshake-mode ACCESS cycles before an abort, 1..65535.
- ERR_DATA, 32'h0000_0000: read data returned on an error.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- m_valid  in  1  master request.
- m_addr  in  32  byte address.
- m_wdata  in  32  write data.
- m_wstrb  in  4  byte strobes; 0 = read.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  32  read data, valid while m_ready is high.
- s_sel  out  NUM_SLAVES  one-hot slave select.
- s_addr  out  32  latched address.
- s_wdata  out  32  latched write data.
- s_wstrb  out  4  write strobes, high in the first ACCESS cycle only.
- s_oe  out  1  read enable, high throughout a read ACCESS.
- s_rdata  in  NUM_SLAVES×32  packed slave read data.
- s_ready  in  NUM_SLAVES  slave ready; used only in handshake mode.
- bus_err  out  1  one-cycle pulse on an unmapped or timed-out access.
- err_addr  out  32  address of the most recent error.

## Operation
- FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - On m_valid, latch the address, wdata and wstrb and decode the slave.
  - When several regions match, the lowest index wins.
  - If no region matches, go to DONE with an error: m_rdata=ERR_DATA, bus_err=1, err_addr=m_addr.
  - Otherwise go to ACCESS with the counter loaded to W, or to TIMEOUT in handshake mode.
- **ACCESS**
  - s_sel[i] is high.
  - s_wstrb carries the latched strobes in the first cycle only, and is 0 afterwards.
  - s_oe = (wstrb==0).
  - Fixed mode: the counter decrements each cycle. At the edge where it equals 1, capture s_rdata[i] (reads only) and go to DONE.
  - Handshake mode: at the first edge where s_ready[i] is high, capture the data and go to DONE.
  - Handshake mode with the counter reaching 1 while s_ready is low: go to DONE with an error; err_addr = latched address.
- **DONE**
  - m_ready=1 for exactly one cycle; s_sel=0; then return to IDLE.
  - m_rdata holds the captured data for reads, ERR_DATA on an error, and 0 on writes.
- m_valid is not re-sampled during ACCESS or DONE. A master that drops its request mid-access still receives the DONE pulse.
- A new request is accepted in IDLE only, and no earlier than the cycle after DONE.
- err_addr holds its value until the next error. bus_err and m_ready are high in the same cycle.

## Timing
- Reset values: m_ready=0, m_rdata=0, s_sel=0, s_addr=0, s_wdata=0, s_wstrb=0, s_oe=0, bus_err=0, err_addr=0; state is IDLE.
- Reset during ACCESS or DONE aborts the transfer: no m_ready pulse and no further slave strobes.
- Counting from the accept edge T0:
  - Fixed mode: ACCESS covers cycles T1..TW and m_ready is high in T(W+1). Throughput is one transfer per W+2 cycles.
  - Handshake mode: if s_ready is first seen high in ACCESS cycle Tk, m_ready is high in T(k+1).
  - Timeout: m_ready and bus_err are high in T(TIMEOUT+1).
  - Unmapped access: m_ready and bus_err are high in T1.
- All outputs are registered. The only combinational logic is the address decode feeding the IDLE state register.

## Structure
- Package rv_bus_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the WAIT_W=4 field width;
  - ERR_DATA_DEFAULT;
  - helper functions that extract field i from the packed BASE, MASK and WAIT vectors.
- Sub-module rv_bus_decode: combinational masked compare plus lowest-index priority encoder. Outputs are a hit flag and an index of $clog2(NUM_SLAVES) bits, minimum 1.
- The top level holds the FSM, the counter (16 bits), the request latches and the read-data capture mux.

## Test plan
- Read 32'h0000_0010 with the default map (slave 0, W=1): s_sel=4'b0001 in T1, s_rdata=32'h1234_5678 → m_ready in T2 with m_rdata=32'h1234_5678; bus_err=0.
- Write 32'h8000_0004, wstrb=4'b0011, to slave 2 with SLV_WAIT=3 → s_wstrb=4'b0011 in T1 only, 0 in T2–T3; m_ready in T4; exactly one strobe cycle.
- Handshake slave 3 (32'h8001_0008) with s_ready asserted in ACCESS cycle 5 → m_ready in T6 with the slave data; no error.
- Handshake slave 3 with s_ready held low, TIMEOUT=8 → m_ready and bus_err in T9, m_rdata=32'h0, err_addr=32'h8001_0008.
- Read of unmapped 32'h4000_0000 → m_ready and bus_err in T1, s_sel stays 0, err_addr=32'h4000_0000.
- rst asserted in T2 of a W=3 access → all outputs 0 in the following cycle, no m_ready; the next request completes normally.

Source files
------------

// File: rtl/rv_bus_pkg.sv
// rtl/rv_bus_pkg.sv - shared types, widths and table accessors for the bus fabric
package rv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int          MAX_SLAVES       = 8;
  localparam int          WAIT_W           = 4;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

  // Region tables are passed zero-padded to MAX_SLAVES entries so one accessor fits any NUM_SLAVES.
  function automatic logic [31:0] base_of(input logic [MAX_SLAVES*32-1:0] vec, input int i);
    return vec[32*i +: 32];
  endfunction

  function automatic logic [31:0] mask_of(input logic [MAX_SLAVES*32-1:0] vec, input int i);
    return vec[32*i +: 32];
  endfunction

  function automatic logic [WAIT_W-1:0] wait_of(input logic [MAX_SLAVES*WAIT_W-1:0] vec,
                                                input int i);
    return vec[WAIT_W*i +: WAIT_W];
  endfunction

endpackage

// File: rtl/rv_bus_decode.sv
// rtl/rv_bus_decode.sv - masked address compare with lowest-index priority
module rv_bus_decode
  import rv_bus_pkg::*;
#(
  parameter int                         NUM_SLAVES = 4,
  parameter int                         IDX_W      = 2,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE   = '0,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK   = '0
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam logic [MAX_SLAVES*32-1:0] BASE_PAD = (MAX_SLAVES*32)'(SLV_BASE);
  localparam logic [MAX_SLAVES*32-1:0] MASK_PAD = (MAX_SLAVES*32)'(SLV_MASK);

  // Scanning from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & mask_of(MASK_PAD, i)) == base_of(BASE_PAD, i)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rv_bus_fabric.sv
// rtl/rv_bus_fabric.sv - table-driven PicoRV32 bus fabric with wait states, handshake and timeout
module rv_bus_fabric
  import rv_bus_pkg::*;
#(
  parameter int                             NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]       SLV_BASE   = {32'h8001_0000, 32'h8000_0000,
                                                          32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]       SLV_MASK   = {32'hFFFF_0000, 32'hFFFF_0000,
                                                          32'hFFFF_0000, 32'hFFFF_0000},
  parameter logic [NUM_SLAVES*WAIT_W-1:0]   SLV_WAIT   = {4'd0, 4'd1, 4'd1, 4'd1},
  parameter int                             TIMEOUT    = 255,
  parameter logic [31:0]                    ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_valid,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_sel,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  output logic                     s_oe,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic                     bus_err,
  output logic [31:0]              err_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [MAX_SLAVES*WAIT_W-1:0] WAIT_PAD = (MAX_SLAVES*WAIT_W)'(SLV_WAIT);

  state_t                  state, state_d;
  logic [15:0]             cnt, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    hs_q, hs_d;
  logic [3:0]              wstrb_q, wstrb_d;

  logic                    m_ready_d, bus_err_d, s_oe_d;
  logic [31:0]             m_rdata_d, s_addr_d, s_wdata_d, err_addr_d;
  logic [NUM_SLAVES-1:0]   s_sel_d;
  logic [3:0]              s_wstrb_d;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [31:0]             rdata_sel;
  logic                    ready_sel;
  logic [WAIT_W-1:0]       wait_sel;
  logic [NUM_SLAVES-1:0]   sel_onehot;

  rv_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Slave-side muxes follow the latched index; wait count and select follow the live decode.
  always_comb begin
    rdata_sel  = '0;
    ready_sel  = 1'b0;
    wait_sel   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rdata_sel = s_rdata[32*i +: 32];
        ready_sel = s_ready[i];
      end
      if (dec_idx == IDX_W'(i)) begin
        wait_sel      = wait_of(WAIT_PAD, i);
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx_q;
    hs_d       = hs_q;
    wstrb_d    = wstrb_q;
    m_ready_d  = 1'b0;
    bus_err_d  = 1'b0;
    s_wstrb_d  = 4'b0000;
    m_rdata_d  = m_rdata;
    s_sel_d    = s_sel;
    s_addr_d   = s_addr;
    s_wdata_d  = s_wdata;
    s_oe_d     = s_oe;
    err_addr_d = err_addr;

    unique case (state)
      IDLE: begin
        if (m_valid) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          wstrb_d   = m_wstrb;
          if (!dec_hit) begin
            state_d    = DONE;
            m_ready_d  = 1'b1;
            bus_err_d  = 1'b1;
            err_addr_d = m_addr;
            m_rdata_d  = ERR_DATA;
          end else begin
            state_d   = ACCESS;
            idx_d     = dec_idx;
            hs_d      = (wait_sel == '0);
            cnt_d     = (wait_sel == '0) ? 16'(TIMEOUT) : 16'(wait_sel);
            s_sel_d   = sel_onehot;
            s_wstrb_d = m_wstrb;
            s_oe_d    = (m_wstrb == 4'b0000);
          end
        end
      end

      ACCESS: begin
        if ((hs_q && ready_sel) || (!hs_q && cnt == 16'd1)) begin
          state_d   = DONE;
          m_ready_d = 1'b1;
          m_rdata_d = (wstrb_q == 4'b0000) ? rdata_sel : 32'h0;
          s_sel_d   = '0;
          s_oe_d    = 1'b0;
        end else if (hs_q && cnt == 16'd1) begin
          state_d    = DONE;
          m_ready_d  = 1'b1;
          bus_err_d  = 1'b1;
          err_addr_d = s_addr;
          m_rdata_d  = ERR_DATA;
          s_sel_d    = '0;
          s_oe_d     = 1'b0;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      hs_q     <= 1'b0;
      wstrb_q  <= '0;
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      s_sel    <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      s_oe     <= 1'b0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx_q    <= idx_d;
      hs_q     <= hs_d;
      wstrb_q  <= wstrb_d;
      m_ready  <= m_ready_d;
      m_rdata  <= m_rdata_d;
      s_sel    <= s_sel_d;
      s_addr   <= s_addr_d;
      s_wdata  <= s_wdata_d;
      s_wstrb  <= s_wstrb_d;
      s_oe     <= s_oe_d;
      bus_err  <= bus_err_d;
      err_addr <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_rv_bus_fabric.sv
// tb/tb_rv_bus_fabric.sv - scoreboard bench for rv_bus_fabric against a region-table model
module tb_rv_bus_fabric;

  localparam int            NS      = 4;
  localparam int            TMO     = 8;
  localparam logic [127:0]  T_BASE  = {32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [127:0]  T_MASK  = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [15:0]   T_WAIT  = {4'd0, 4'd3, 4'd2, 4'd1};

  // Reference region table, slave 0 first; slave 3 overlaps slave 2 to exercise priority.
  int unsigned mdl_base [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000};
  int unsigned mdl_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};
  int          mdl_wait [NS] = '{1, 2, 3, 0};

  logic         clk = 1'b0;
  logic         rst;
  logic         m_valid;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [NS-1:0] s_sel;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_oe;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0] s_ready;
  logic         bus_err;
  logic [31:0]  err_addr;

  typedef struct {
    time         t;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] err_addr;
    logic        err;
    logic [3:0]  sel;
    logic [3:0]  wstrb;
    int          nstrobe;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          hs_delay = 0;
  int          strobe_cnt = 0;
  logic [31:0] last_err = 32'h0;

  rv_bus_fabric #(
    .NUM_SLAVES (NS),
    .SLV_BASE   (T_BASE),
    .SLV_MASK   (T_MASK),
    .SLV_WAIT   (T_WAIT),
    .TIMEOUT    (TMO),
    .ERR_DATA   (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .s_sel    (s_sel),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_oe     (s_oe),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake slave 3 raises ready in its hs_delay-th ACCESS cycle; other ready bits are noise.
  initial begin
    int          acc = 0;
    logic [31:0] noise;
    s_ready = '0;
    forever begin
      @(negedge clk);
      acc   = s_sel[3] ? acc + 1 : 0;
      noise = $urandom;
      s_ready = {(s_sel[3] && acc == hs_delay), noise[2:0]};
    end
  end

  task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int hsd, input logic [31:0] rd);
    exp_t e;
    time  t0;
    int   idx, n, k;
    @(negedge clk);
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = rd + 32'(i);
    hs_delay = hsd;
    m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
    @(posedge clk);
    t0  = $time;
    idx = -1;
    for (int i = 0; i < NS; i++)
      if ((a & mdl_mask[i]) == mdl_base[i]) begin idx = i; break; end
    e.addr = a; e.wdata = wd; e.wstrb = ws;
    if (idx < 0) begin
      n = 0; e.err = 1'b1; e.sel = 4'b0; e.nstrobe = 0; last_err = a;
    end else begin
      e.sel = 4'(1 << idx);
      e.nstrobe = (ws != 4'b0) ? 1 : 0;
      if (mdl_wait[idx] != 0) begin n = mdl_wait[idx]; e.err = 1'b0; end
      else if (hsd <= TMO)    begin n = hsd;           e.err = 1'b0; end
      else                    begin n = TMO;           e.err = 1'b1; last_err = a; end
    end
    e.rdata    = e.err ? 32'h0 : ((ws == 4'b0) ? rd + 32'(idx) : 32'h0);
    e.err_addr = last_err;
    e.t        = t0 + 10 * (n + 1) - 5;
    sb.push_back(e);
    @(negedge clk);
    m_valid = 1'b0; m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom);
    for (k = 0; k < 40; k++) begin
      if (m_ready) break;
      @(negedge clk);
    end
    if (k == 40) chk("completion_timeout", 32'(k), 32'd0);
  endtask

  // Monitor: slave-side checks during ACCESS, response checks on every m_ready pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (s_wstrb != 4'b0) begin
        strobe_cnt++;
        if (sb.size() > 0) chk("s_wstrb_value", 32'(s_wstrb), 32'(sb[0].wstrb));
      end
      if (s_sel != '0 && sb.size() > 0) begin
        chk("s_sel", 32'(s_sel), 32'(sb[0].sel));
        chk("s_oe", 32'(s_oe), 32'(sb[0].wstrb == 4'b0));
        chk("s_addr", s_addr, sb[0].addr);
        chk("s_wdata", s_wdata, sb[0].wdata);
      end
      if (bus_err && !m_ready) chk("bus_err_without_ready", 32'(bus_err), 32'd0);
      if (m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_m_ready", 32'(m_ready), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ready_time", 32'($time), 32'(e.t));
          chk("m_rdata", m_rdata, e.rdata);
          chk("bus_err", 32'(bus_err), 32'(e.err));
          chk("err_addr", err_addr, e.err_addr);
          chk("strobe_count", 32'(strobe_cnt), 32'(e.nstrobe));
          chk("s_sel_in_done", 32'(s_sel), 32'd0);
        end
        strobe_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] a, r;
    int          sel;
    rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0; s_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({m_ready, s_sel, s_wstrb, s_oe, bus_err}), 32'd0);
    chk("reset_data", m_rdata | s_addr | s_wdata | err_addr, 32'd0);
    rst = 1'b0;

    do_xfer(32'h0000_0010, 32'h0, 4'b0000, 0, 32'h1234_5678);
    do_xfer(32'h8000_0004, 32'hA5A5_5A5A, 4'b0011, 0, $urandom);
    do_xfer(32'h8001_0008, 32'h0, 4'b0000, 5, $urandom);
    do_xfer(32'h8001_0008, 32'h0, 4'b0000, 1000, $urandom);
    do_xfer(32'h4000_0000, 32'h0, 4'b0000, 0, $urandom);
    do_xfer(32'h8001_0010, 32'h0, 4'b0000, 1, $urandom);
    do_xfer(32'h8001_0014, 32'h1111_2222, 4'b1000, TMO, $urandom);

    // Reset while a W=3 read is in its second ACCESS cycle.
    @(negedge clk);
    s_rdata = {4{32'hCAFE_0000}};
    m_valid = 1'b1; m_addr = 32'h8000_0020; m_wstrb = 4'b0000;
    @(posedge clk);
    @(negedge clk); m_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", 32'({m_ready, s_sel, s_wstrb, s_oe, bus_err}), 32'd0);
    chk("abort_data", m_rdata | s_addr | s_wdata | err_addr, 32'd0);
    rst = 1'b0;
    last_err = 32'h0;
    repeat (5) begin
      @(negedge clk);
      chk("no_ready_after_abort", 32'({m_ready, s_sel}), 32'd0);
    end
    do_xfer(32'h8000_0020, 32'h0, 4'b0000, 0, 32'h0BAD_F00D);

    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 5);
      r   = $urandom;
      case (sel)
        0:       a = {16'h0000, r[15:0]};
        1:       a = {16'h0001, r[15:0]};
        2:       a = {16'h8000, r[15:0]};
        3:       a = {16'h8001, r[15:0]};
        4:       a = {12'h800, r[19:0]};
        default: a = $urandom;
      endcase
      r = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_xfer(a, $urandom, (r[0] ? 4'(r[7:4]) : 4'b0000), $urandom_range(1, TMO + 2), $urandom);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish, got %0d checks", checks);
    $fatal(1);
  end

endmodule
